// File: rtl/booth_pkg.sv
// Shared encodings for the Booth multiplier family: FSM states and the
// recoded-digit magnitude set.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Digit value is (neg ? -1 : +1) * magnitude.
  typedef enum logic [1:0] {
    DIG_ZERO = 2'd0,
    DIG_ONE  = 2'd1,
    DIG_TWO  = 2'd2
  } digit_mag_e;

  localparam int DIG_WINDOW_W = 3;

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: {q[i+1], q[i], q[i-1]} -> digit magnitude and sign.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [DIG_WINDOW_W-1:0] window_i,
  output digit_mag_e              mag_o,
  output logic                    neg_o
);

  always_comb begin
    mag_o = DIG_ZERO;
    neg_o = 1'b0;
    case (window_i)
      3'b001, 3'b010: mag_o = DIG_ONE;
      3'b011:         mag_o = DIG_TWO;
      3'b100: begin
        mag_o = DIG_TWO;
        neg_o = 1'b1;
      end
      3'b101, 3'b110: begin
        mag_o = DIG_ONE;
        neg_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, signed or unsigned
// operands selected per multiply.
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = WIDTH / 2 + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     Q_in,
  input  logic [WIDTH-1:0]     M_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Product_out
);

  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + 3;
  localparam int CW = $clog2(ITER);

  state_e              state_q;
  logic [AW-1:0]       acc_q;
  logic [XW-1:0]       mplr_q;
  logic [XW-1:0]       mcnd_q;
  logic                prev_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [2*WIDTH-1:0]  prod_q;

  digit_mag_e          mag;
  logic                neg;
  logic [AW-1:0]       mag_term_d;
  logic [AW-1:0]       term_d;
  logic [AW-1:0]       sum_d;
  logic [AW-1:0]       acc_d;
  logic [XW-1:0]       mplr_d;

  booth_r4_recoder u_recoder (
    .window_i ({mplr_q[1:0], prev_q}),
    .mag_o    (mag),
    .neg_o    (neg)
  );

  // Accumulator and multiplier form one shift register {acc, mplr}; each step
  // adds the digit term into acc and shifts the pair right by two arithmetically.
  always_comb begin
    mag_term_d = '0;
    case (mag)
      DIG_ONE: mag_term_d = {mcnd_q[XW-1], mcnd_q};
      DIG_TWO: mag_term_d = {mcnd_q, 1'b0};
      default: mag_term_d = '0;
    endcase
    term_d = neg ? (~mag_term_d + AW'(1)) : mag_term_d;
    sum_d  = acc_q + term_d;
    acc_d  = {{2{sum_d[AW-1]}}, sum_d[AW-1:2]};
    mplr_d = {sum_d[1:0], mplr_q[XW-1:2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcnd_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_CALC: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_d;
          prev_q <= mplr_q[1];
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
          end
        end
        ST_FIN: begin
          prod_q  <= {acc_q[2*WIDTH-XW-1:0], mplr_q};
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // A capture overrides the IDLE fall-through of FIN for back-to-back use.
      if (start && state_q != ST_CALC) begin
        mplr_q  <= {{2{signed_mode & Q_in[WIDTH-1]}}, Q_in};
        mcnd_q  <= {{2{signed_mode & M_in[WIDTH-1]}}, M_in};
        prev_q  <= 1'b0;
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= ST_CALC;
        busy_q  <= 1'b1;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Product_out = prod_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench: directed corner scenarios at WIDTH=8 plus randomized
// multiplies at WIDTH=4/8/16 compared with a plain-arithmetic product model.
module tb_booth_radix4_mult;

  logic        clk;
  logic        rst;
  logic        smode;
  logic        start4, start8, start16;
  logic [3:0]  q4, m4;
  logic [7:0]  q8, m8;
  logic [15:0] q16, m16;
  logic        busy4, busy8, busy16;
  logic        done4, done8, done16;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int total = 0;
  int bad   = 0;

  booth_radix4_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(smode),
    .Q_in(q4), .M_in(m4), .busy(busy4), .done(done4), .Product_out(prod4)
  );
  booth_radix4_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(smode),
    .Q_in(q8), .M_in(m8), .busy(busy8), .done(done8), .Product_out(prod8)
  );
  booth_radix4_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(smode),
    .Q_in(q16), .M_in(m16), .busy(busy16), .done(done16), .Product_out(prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int w);
    case (w)
      4:       return done4;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:       return busy4;
      8:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int w);
    case (w)
      4:       return {24'b0, prod4};
      8:       return {16'b0, prod8};
      default: return prod16;
    endcase
  endfunction

  task automatic set_ops(input int w, input logic s, input logic [31:0] q, input logic [31:0] m);
    case (w)
      4:       begin start4  = s; q4  = q[3:0];  m4  = m[3:0];  end
      8:       begin start8  = s; q8  = q[7:0];  m8  = m[7:0];  end
      default: begin start16 = s; q16 = q[15:0]; m16 = m[15:0]; end
    endcase
  endtask

  // Exact product of the operands as interpreted in the chosen mode, truncated to 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input bit sm,
                                           input logic [31:0] q, input logic [31:0] m);
    longint a, b, p;
    logic [63:0] mask;
    a = longint'(q);
    b = longint'(m);
    if (sm && q[w-1]) a = a - (longint'(1) << w);
    if (sm && m[w-1]) b = b - (longint'(1) << w);
    p = a * b;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // Presents operands for one edge, then scrambles inputs and mode to prove capture.
  task automatic launch(input int w, input bit sm, input logic [31:0] q, input logic [31:0] m);
    smode = sm;
    set_ops(w, 1'b1, q, m);
    @(posedge clk);
    #1;
    set_ops(w, 1'b0, $urandom, $urandom);
    smode = ~sm;
  endtask

  task automatic wait_done(input int w, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (get_done(w)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input int w, input bit sm, input logic [31:0] q, input logic [31:0] m,
                        input string tag);
    int lat;
    logic [63:0] exp;
    exp = ref_prod(w, sm, q, m);
    launch(w, sm, q, m);
    wait_done(w, lat);
    check_val({tag, "_lat"}, 64'(lat), 64'(w / 2 + 2));
    check_val({tag, "_prod"}, 64'(get_prod(w)), exp);
    $display("op %s w=%0d s=%0d q=%0h m=%0h prod=%0h exp=%0h lat=%0d",
             tag, w, sm, q, m, get_prod(w), exp, lat);
  endtask

  initial begin
    int lat;
    int n;
    int ws[3];
    logic [31:0] mask, q, m;
    ws = '{4, 8, 16};

    rst = 1'b1;
    smode = 1'b0;
    set_ops(4, 1'b0, 0, 0);
    set_ops(8, 1'b0, 0, 0);
    set_ops(16, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(busy8), 64'd0);
    check_val("rst_done", 64'(done8), 64'd0);
    check_val("rst_prod", 64'(prod8), 64'd0);
    rst = 1'b0;

    run_op(8, 1'b1, 32'd7, 32'd5, "s7x5");
    run_op(8, 1'b1, 32'hFD, 32'd6, "sm3x6");
    run_op(8, 1'b1, 32'h80, 32'h80, "smin_sq");
    run_op(8, 1'b0, 32'hFF, 32'hFF, "u255sq");
    run_op(8, 1'b1, 32'hFF, 32'hFF, "sm1sq");
    check_val("sm1sq_const", 64'(prod8), 64'h0001);

    // New start while iterating must be ignored.
    launch(8, 1'b1, 32'd12, 32'd11);
    @(posedge clk);
    #1;
    check_val("calc_busy", 64'(busy8), 64'd1);
    smode = 1'b1;
    set_ops(8, 1'b1, 32'd3, 32'd3);
    @(posedge clk);
    #1;
    set_ops(8, 1'b0, 32'd0, 32'd0);
    wait_done(8, lat);
    check_val("ign_lat", 64'(lat), 64'd4);
    check_val("ign_prod", 64'(prod8), 64'd132);
    n = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8) n++;
    end
    check_val("ign_extra_done", 64'(n), 64'd0);
    $display("op ign_calc prod=%0h", prod8);

    // Start presented in FIN chains straight into the next multiply.
    launch(8, 1'b1, 32'd9, 32'd10);
    repeat (5) @(posedge clk);
    #1;
    check_val("fin_busy", 64'(busy8), 64'd0);
    smode = 1'b1;
    set_ops(8, 1'b1, 32'd4, 32'hF9);
    @(posedge clk);
    #1;
    check_val("fin_done", 64'(done8), 64'd1);
    check_val("fin_prod1", 64'(prod8), 64'd90);
    check_val("fin_rebusy", 64'(busy8), 64'd1);
    set_ops(8, 1'b0, $urandom, $urandom);
    smode = 1'b0;
    wait_done(8, lat);
    check_val("b2b_lat", 64'(lat), 64'd6);
    check_val("b2b_prod", 64'(prod8), 64'hFFE4);
    $display("op b2b prod=%0h lat=%0d", prod8, lat);

    // Reset in the middle of an operation aborts it.
    launch(8, 1'b1, 32'd127, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("abort_busy", 64'(busy8), 64'd0);
    check_val("abort_done", 64'(done8), 64'd0);
    check_val("abort_prod", 64'(prod8), 64'd0);
    n = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8) n++;
    end
    check_val("abort_no_done", 64'(n), 64'd0);
    $display("op abort prod=%0h", prod8);
    run_op(8, 1'b1, 32'd127, 32'd1, "after_abort");

    for (int wi = 0; wi < 3; wi++) begin
      mask = (32'd1 << ws[wi]) - 32'd1;
      for (int sm = 0; sm < 2; sm++) begin
        for (int i = 0; i < 20; i++) begin
          q = $urandom & mask;
          m = $urandom & mask;
          if (i == 0) begin
            q = 32'd1 << (ws[wi] - 1);
            m = q;
          end else if (i == 1) begin
            q = mask;
            m = 32'd1 << (ws[wi] - 1);
          end
          run_op(ws[wi], sm[0], q, m, "rnd");
          check_val("rnd_idle_busy", 64'(get_busy(ws[wi])), 64'd0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
